// File: rtl/example_sdiv_pkg.sv
// Shared widths, saturation limits and FSM state type for the sequential signed divider.
package example_sdiv_pkg;

  localparam int unsigned DIN0_W = 21;
  localparam int unsigned DIN1_W = 9;
  localparam int unsigned DOUT_W = 14;
  localparam int unsigned PATH_W = 22;
  localparam int unsigned QBITS  = PATH_W - 1;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned N_ITER = 21;

  localparam int QMAX = 8191;
  localparam int QMIN = -8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/example_sdiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module example_sdiv_step
  import example_sdiv_pkg::*;
(
  input  logic [DIN1_W-1:0] prem,
  input  logic [PATH_W-1:0] quo,
  input  logic [DIN1_W-1:0] dvs,
  output logic [DIN1_W-1:0] prem_nxt,
  output logic [PATH_W-1:0] quo_nxt
);

  logic [DIN1_W:0] shifted;
  logic [DIN1_W:0] diff;
  logic            ge;

  assign shifted  = {prem, quo[QBITS-1]};
  assign ge       = (shifted >= {1'b0, dvs});
  assign diff     = shifted - {1'b0, dvs};
  assign prem_nxt = DIN1_W'(ge ? diff : shifted);
  // Dividend bits leave through bit QBITS-1 while quotient bits enter at bit 0; the top bit stays clear.
  assign quo_nxt  = {1'b0, QBITS'({quo, ge})};

endmodule

// File: rtl/example_sdiv_21s_9s_seq.sv
// Sequential 21-bit by 9-bit signed divider with C truncation semantics, quotient saturation
// to 14 bits and divide-by-zero flagging; fixed 23-cycle latency.
module example_sdiv_21s_9s_seq
  import example_sdiv_pkg::*;
#(
  parameter int ID         = 32'd1,
  parameter int din0_WIDTH = 32'd21,
  parameter int din1_WIDTH = 32'd9,
  parameter int dout_WIDTH = 32'd14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);

  if (din0_WIDTH != int'(DIN0_W) || din1_WIDTH != int'(DIN1_W) ||
      dout_WIDTH != int'(DOUT_W)) begin : g_width_check
    $error("example_sdiv_21s_9s_seq ID=%0d: only 21/9/14 widths are supported", ID);
  end

  localparam logic signed [PATH_W-1:0] Q_HI = PATH_W'(QMAX);
  localparam logic signed [PATH_W-1:0] Q_LO = PATH_W'(QMIN);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [PATH_W-1:0]         quo;
  logic [DIN1_W-1:0]         prem;
  logic [DIN1_W-1:0]         dvs;
  logic                      q_neg;
  logic                      r_neg;
  logic                      d_zero;
  logic signed [PATH_W-1:0]  q_fix;
  logic signed [DIN1_W-1:0]  r_fix;

  logic signed [PATH_W-1:0]  a_ext;
  logic signed [DIN1_W:0]    b_ext;
  logic [PATH_W-1:0]         a_mag;
  logic [DIN1_W-1:0]         b_mag;
  logic [DIN1_W-1:0]         prem_nxt;
  logic [PATH_W-1:0]         quo_nxt;

  // Magnitudes are formed one bit wider than the operands so -2^20 and -256 do not wrap.
  assign a_ext = PATH_W'($signed(din0));
  assign b_ext = (DIN1_W+1)'($signed(din1));
  assign a_mag = PATH_W'(a_ext[PATH_W-1] ? -a_ext : a_ext);
  assign b_mag = DIN1_W'(b_ext[DIN1_W] ? -b_ext : b_ext);

  example_sdiv_step u_step (
    .prem     (prem),
    .quo      (quo),
    .dvs      (dvs),
    .prem_nxt (prem_nxt),
    .quo_nxt  (quo_nxt)
  );

  // Control FSM, iteration counter, sign fix-up and result registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      prem   <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      d_zero <= 1'b0;
      q_fix  <= '0;
      r_fix  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
      rem    <= '0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            cnt    <= CNT_W'(N_ITER - 1);
            quo    <= a_mag;
            prem   <= '0;
            dvs    <= b_mag;
            q_neg  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            r_neg  <= din0[din0_WIDTH-1];
            d_zero <= (din1 == '0);
            busy   <= 1'b1;
          end
        end
        CALC: begin
          quo  <= quo_nxt;
          prem <= prem_nxt;
          if (cnt == '0) begin
            state <= FIX;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          // First FIX cycle applies signs; second saturates and publishes.
          if (cnt != '0) begin
            cnt   <= '0;
            q_fix <= q_neg ? -$signed(quo) : $signed(quo);
            r_fix <= r_neg ? -$signed(prem) : $signed(prem);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (d_zero) begin
              dout <= r_neg ? DOUT_W'(QMIN) : DOUT_W'(QMAX);
              rem  <= '0;
              ovf  <= 1'b0;
              dz   <= 1'b1;
            end else begin
              rem <= r_fix;
              dz  <= 1'b0;
              if (q_fix > Q_HI) begin
                dout <= DOUT_W'(QMAX);
                ovf  <= 1'b1;
              end else if (q_fix < Q_LO) begin
                dout <= DOUT_W'(QMIN);
                ovf  <= 1'b1;
              end else begin
                dout <= DOUT_W'(q_fix);
                ovf  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_example_sdiv_21s_9s_seq.sv
// Scoreboard bench for example_sdiv_21s_9s_seq: directed divisions with hand-computed results.
module tb_example_sdiv_21s_9s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce;
  logic        start;
  logic [20:0] din0;
  logic [8:0]  din1;
  logic        busy;
  logic        done;
  logic [13:0] dout;
  logic [8:0]  rem;
  logic        ovf;
  logic        dz;

  typedef struct {
    string       name;
    logic [13:0] q;
    logic [8:0]  r;
    logic        ovf;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic done_q   = 1'b0;

  example_sdiv_21s_9s_seq #(
    .ID         (1),
    .din0_WIDTH (21),
    .din1_WIDTH (9),
    .dout_WIDTH (14)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dz       (dz)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  // Monitor: every rising done pops one expectation and checks results and latency.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with nothing pending at cycle %0d, required no done", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, "_dout"}, 32'(dout), 32'(mon_e.q));
          chk({mon_e.name, "_rem"},  32'(rem),  32'(mon_e.r));
          chk({mon_e.name, "_ovf"},  32'(ovf),  32'(mon_e.ovf));
          chk({mon_e.name, "_dz"},   32'(dz),   32'(mon_e.dz));
          chk({mon_e.name, "_lat"},  32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk({mon_e.name, "_busy"}, 32'(busy), 32'd0);
        end
      end
      done_q = done;
    end
  end

  task automatic issue(input string nm, input int a, input int b, input int q, input int r,
                       input bit o, input bit z, input int lat);
    exp_t e;
    @(negedge ap_clk);
    din0  = 21'(a);
    din1  = 9'(b);
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    e.name = nm;
    e.q    = 14'(q);
    e.r    = 9'(r);
    e.ovf  = o;
    e.dz   = z;
    e.acc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge ap_clk);
      k++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d results pending after 100 cycles, required 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic op(input string nm, input int a, input int b, input int q, input int r,
                    input bit o, input bit z);
    logic [13:0] qx;
    logic [8:0]  rx;
    qx = 14'(q);
    rx = 9'(r);
    issue(nm, a, b, q, r, o, z, 23);
    wait_drain(nm);
    repeat (3) @(negedge ap_clk);
    chk({nm, "_hold_dout"}, 32'(dout), 32'(qx));
    chk({nm, "_hold_rem"},  32'(rem),  32'(rx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] q142;
    ap_rst_n = 1'b0;
    ce       = 1'b1;
    start    = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (2) @(negedge ap_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_rem",  32'(rem),  32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    chk("rst_dz",   32'(dz),   32'd0);
    ap_rst_n = 1'b1;

    op("p1000_7",    1000,     7,    142,   6,  1'b0, 1'b0);
    op("n1000_7",   -1000,     7,   -142,  -6,  1'b0, 1'b0);
    op("p1000_n7",   1000,    -7,   -142,   6,  1'b0, 1'b0);
    op("p12345_n17", 12345,  -17,   -726,   3,  1'b0, 1'b0);
    op("n12345_n17", -12345, -17,    726,  -3,  1'b0, 1'b0);
    op("max_1",      1048575,  1,   8191,   0,  1'b1, 1'b0);
    op("min_n256",  -1048576, -256, 4096,   0,  1'b0, 1'b0);
    op("min_n1",    -1048576, -1,   8191,   0,  1'b1, 1'b0);
    op("min_1",     -1048576,  1,  -8192,   0,  1'b1, 1'b0);
    op("p5_0",       5,        0,   8191,   0,  1'b0, 1'b1);
    op("n5_0",      -5,        0,  -8192,   0,  1'b0, 1'b1);

    // Reset in the middle of CALC: outputs clear at once and the operation never completes.
    issue("abort", 1000, 7, 142, 6, 1'b0, 1'b0, 23);
    repeat (9) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_rem",  32'(rem),  32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    chk("abort_dz",   32'(dz),   32'd0);
    sb.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (30) @(negedge ap_clk);
    op("after_rst", 100, 10, 10, 0, 1'b0, 1'b0);

    // start pulses while busy must be dropped, not queued.
    issue("ign", 1000, 7, 142, 6, 1'b0, 1'b0, 23);
    repeat (2) @(negedge ap_clk);
    din0  = 21'(5);
    din1  = 9'(0);
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    repeat (6) @(negedge ap_clk);
    din0  = 21'(-1000);
    din1  = 9'(3);
    start = 1'b1;
    @(negedge ap_clk);
    start = 1'b0;
    wait_drain("ign");
    repeat (30) @(negedge ap_clk);
    q142 = 14'(142);
    chk("ign_busy_after", 32'(busy), 32'd0);
    chk("ign_dout_after", 32'(dout), 32'(q142));

    // ce held low for 5 cycles mid-CALC stretches the latency by exactly 5 cycles.
    issue("ce_gap", -1000, 7, -142, -6, 1'b0, 1'b0, 28);
    repeat (7) @(negedge ap_clk);
    ce = 1'b0;
    repeat (5) @(negedge ap_clk);
    chk("ce_gap_busy_frozen", 32'(busy), 32'd1);
    ce = 1'b1;
    wait_drain("ce_gap");
    repeat (3) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/example_sdiv_21s_9s_seq.md
EXAMPLE_SDIV_21S_9S_SEQ -- requirements
Module: example_sdiv_21s_9s_seq

Interface
REQ-001 SHALL have parameters: ID, 32'd1, instance identifier with no functional effect.
REQ-002 SHALL have parameters: din0_WIDTH, 32'd21, dividend width; din1_WIDTH, 32'd9, divisor width; dout_WIDTH, 32'd14, quotient width; only these values are supported.
REQ-003 SHALL use one clock, ap_clk; reset is asynchronous and active-low, ap_rst_n.
REQ-004 ports: ap_clk  in  1  clock, rising edge.
REQ-005 ports: ap_rst_n  in  1  async active-low reset.
REQ-006 ports: ce  in  1  clock enable; low freezes all state and outputs.
REQ-007 ports: start  in  1  request; sampled only in IDLE with ce=1.
REQ-008 ports: din0  in  21  signed dividend; din1  in  9  signed divisor; both captured at accept.
REQ-009 ports: busy  out  1  high while an operation is in flight.
REQ-010 ports: done  out  1  one-cycle pulse; results valid from that cycle until the next accept.
REQ-011 ports: dout  out  14  signed quotient; rem  out  9  signed remainder.
REQ-012 ports: ovf  out  1  quotient saturated; dz  out  1  divisor was zero.

Function
REQ-013 SHALL compute C semantics: quotient truncated toward zero; remainder takes the dividend's sign; din0 = q*din1 + rem when no flag is set.
REQ-014 SHALL use an FSM with states IDLE, CALC and FIX.
REQ-015 IDLE to CALC on start=1 with ce=1 (accept edge); capture magnitudes and signs; load iteration counter with 20.
REQ-016 CALC SHALL perform one restoring-division step per enabled cycle over 21 iterations, using a 22-bit unsigned quotient/partial-remainder datapath; at counter 0 go to FIX.
REQ-017 FIX SHALL apply signs, saturate, register dout/rem/ovf/dz, pulse done, and return to IDLE.
REQ-018 Latency SHALL be fixed: done high after exactly 23 enabled edges following the accept edge, including the divide-by-zero case.
REQ-019 busy SHALL be high from the edge after accept through the FIX cycle; busy=0 in the done-visible cycle.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 Overflow: true quotient > 8191 gives dout=8191 and ovf=1; true quotient < -8192 gives dout=-8192 and ovf=1; rem stays the true remainder.
REQ-022 Divide by zero: dz=1, ovf=0, rem=0; dout=8191 if din0>=0, else -8192.
REQ-023 Worst case -1048576/-1 SHALL not wrap internally: the 22-bit magnitude path is required.
REQ-024 With ce=0 mid-operation, counter, state and done SHALL hold; a pending done pulse stretches until the next enabled edge.
REQ-025 dout, rem, ovf and dz SHALL hold their last values while IDLE.

Reset
REQ-026 ap_rst_n low SHALL immediately force IDLE, busy=0, done=0, dout=0, rem=0, ovf=0, dz=0, counter=0, at any point including mid-CALC.
REQ-027 An aborted operation SHALL produce no done; the first accept after reset deassertion is serviced normally.

Structure
REQ-028 Package example_sdiv_pkg SHALL hold the width constants (21/9/14/22), the state enum, and saturation constants QMAX=8191 and QMIN=-8192.
REQ-029 One combinational sub-module, example_sdiv_step, SHALL implement a single shift/trial-subtract/restore iteration; the top holds the FSM, counter, sign handling and output registers.

Verification
REQ-030 1000/7 -> dout=142, rem=6, ovf=0, dz=0, done 23 edges after accept.
REQ-031 -1000/7 -> dout=-142, rem=-6; 1000/-7 -> dout=-142, rem=6.
REQ-032 1048575/1 -> dout=8191, ovf=1; -1048576/-256 -> dout=4096, rem=0, ovf=0.
REQ-033 5/0 -> dz=1, dout=8191, rem=0; -5/0 -> dz=1, dout=-8192; latency still 23.
REQ-034 start pulsed at cycles 3 and 10 after accept -> ignored, exactly one done; ce low for 5 cycles mid-CALC -> done delayed by exactly 5 cycles.
REQ-035 ap_rst_n low at cycle 10 of CALC -> all outputs 0 immediately, no done; the next operation 100/10 -> dout=10, rem=0.
